// File: rtl/ucsbece154b_hazard_ctrl.sv
// Control decode, E/M/W control pipeline, branch resolution, forwarding, load-use
// detection and multi-cycle MUL stall sequencing for the 5-stage RISC-V pipeline.
module ucsbece154b_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MUL_LAT    = 3,
    parameter int ENABLE_MUL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7b5_i,
    input  logic              funct7b0_i,
    input  logic              ZeroE_i,
    input  logic [REG_AW-1:0] Rs1D_i,
    input  logic [REG_AW-1:0] Rs2D_i,
    input  logic [REG_AW-1:0] Rs1E_i,
    input  logic [REG_AW-1:0] Rs2E_i,
    input  logic [REG_AW-1:0] RdE_i,
    input  logic [REG_AW-1:0] RdM_i,
    input  logic [REG_AW-1:0] RdW_i,
    output logic              StallF_o,
    output logic              StallD_o,
    output logic              StallE_o,
    output logic              FlushD_o,
    output logic              FlushE_o,
    output logic [2:0]        ImmSrcD_o,
    output logic              PCSrcE_o,
    output logic              PCTargetSrcE_o,
    output logic [3:0]        ALUControlE_o,
    output logic              ALUSrcE_o,
    output logic [1:0]        ForwardAE_o,
    output logic [1:0]        ForwardBE_o,
    output logic              MemWriteM_o,
    output logic [1:0]        ResultSrcM_o,
    output logic [1:0]        ResultSrcW_o,
    output logic              RegWriteM_o,
    output logic              RegWriteW_o
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    localparam bit MUL_EN     = (ENABLE_MUL != 0);
    localparam bit MUL_STALLS = MUL_EN && (MUL_LAT > 1);
    localparam int CNT_W      = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam int CNT_INIT   = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
        logic       branch;
        logic       branchNe;
        logic       jump;
        logic       jalr;
        logic [3:0] aluControl;
        logic       aluSrc;
        logic       mul;
    } idExT;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
    } exMemT;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
    } memWbT;

    typedef enum logic {IDLE, BUSY} mulStateT;

    idExT             ctrlD;
    logic [3:0]       aluFunctD;
    logic [2:0]       immSrcD;
    idExT             idEx_d, idEx_q;
    exMemT            exMem_d, exMem_q;
    memWbT            memWb_d, memWb_q;
    mulStateT         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pcSrcE, mulStall, lwStallRaw, lwStall, flushE;

    always_comb begin
        ctrlD   = '0;
        immSrcD = 3'b000;
        case (funct3_i)
            3'b000:  aluFunctD = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b010:  aluFunctD = ALU_SLT;
            3'b110:  aluFunctD = ALU_OR;
            3'b111:  aluFunctD = ALU_AND;
            default: aluFunctD = ALU_ADD;
        endcase
        case (op_i)
            OP_R: begin
                ctrlD.regWrite   = 1'b1;
                ctrlD.mul        = MUL_EN & funct7b0_i;
                ctrlD.aluControl = (MUL_EN && funct7b0_i) ? ALU_MUL : aluFunctD;
            end
            OP_I: begin
                ctrlD.regWrite   = 1'b1;
                ctrlD.aluSrc     = 1'b1;
                ctrlD.aluControl = aluFunctD;
            end
            OP_LW: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = 2'b01;
                ctrlD.aluSrc    = 1'b1;
            end
            OP_SW: begin
                ctrlD.memWrite = 1'b1;
                ctrlD.aluSrc   = 1'b1;
                immSrcD        = 3'b001;
            end
            OP_BR: begin
                ctrlD.branch     = 1'b1;
                ctrlD.branchNe   = (funct3_i == 3'b001);
                ctrlD.aluControl = ALU_SUB;
                immSrcD          = 3'b010;
            end
            OP_JAL: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = 2'b10;
                ctrlD.jump      = 1'b1;
                immSrcD         = 3'b011;
            end
            OP_JALR: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = 2'b10;
                ctrlD.jalr      = 1'b1;
                ctrlD.aluSrc    = 1'b1;
            end
            OP_LUI: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = 2'b11;
                immSrcD         = 3'b100;
            end
            default: ctrlD = '0;
        endcase
    end

    // A MUL stall always wins: it masks both the load-use stall and the E flush.
    always_comb begin
        pcSrcE     = idEx_q.jump | idEx_q.jalr | (idEx_q.branch & (ZeroE_i ^ idEx_q.branchNe));
        mulStall   = (state_q == IDLE && idEx_q.mul && MUL_STALLS) ||
                     (state_q == BUSY && cnt_q != '0);
        lwStallRaw = (idEx_q.resultSrc == 2'b01) && (RdE_i != '0) &&
                     ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));
        lwStall    = lwStallRaw & ~mulStall;
        flushE     = ~mulStall & (pcSrcE | lwStall);
    end

    always_comb begin
        if (mulStall)    idEx_d = idEx_q;
        else if (flushE) idEx_d = '0;
        else             idEx_d = ctrlD;
        exMem_d = mulStall ? '0 : '{idEx_q.regWrite, idEx_q.resultSrc, idEx_q.memWrite};
        memWb_d = '{exMem_q.regWrite, exMem_q.resultSrc};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idEx_q  <= '0;
            exMem_q <= '0;
            memWb_q <= '0;
        end else begin
            idEx_q  <= idEx_d;
            exMem_q <= exMem_d;
            memWb_q <= memWb_d;
        end
    end

    // The cycle that leaves BUSY (cnt_q == 0) is the MUL's final E cycle and does not stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (idEx_q.mul && MUL_STALLS) begin
                    state_q <= BUSY;
                    cnt_q   <= CNT_W'(CNT_INIT);
                end
                BUSY: if (cnt_q == '0) state_q <= IDLE;
                      else             cnt_q   <= cnt_q - 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs,
                                          input logic [REG_AW-1:0] rdM, input logic wrM,
                                          input logic [REG_AW-1:0] rdW, input logic wrW);
        if (rs != '0 && rs == rdM && wrM)      return 2'b10;
        else if (rs != '0 && rs == rdW && wrW) return 2'b01;
        else                                   return 2'b00;
    endfunction

    assign ForwardAE_o    = fwdSel(Rs1E_i, RdM_i, exMem_q.regWrite, RdW_i, memWb_q.regWrite);
    assign ForwardBE_o    = fwdSel(Rs2E_i, RdM_i, exMem_q.regWrite, RdW_i, memWb_q.regWrite);
    assign StallF_o       = mulStall | lwStall;
    assign StallD_o       = mulStall | lwStall;
    assign StallE_o       = mulStall;
    assign FlushD_o       = pcSrcE;
    assign FlushE_o       = flushE;
    assign ImmSrcD_o      = immSrcD;
    assign PCSrcE_o       = pcSrcE;
    assign PCTargetSrcE_o = idEx_q.jalr;
    assign ALUControlE_o  = idEx_q.aluControl;
    assign ALUSrcE_o      = idEx_q.aluSrc;
    assign MemWriteM_o    = exMem_q.memWrite;
    assign ResultSrcM_o   = exMem_q.resultSrc;
    assign RegWriteM_o    = exMem_q.regWrite;
    assign ResultSrcW_o   = memWb_q.resultSrc;
    assign RegWriteW_o    = memWb_q.regWrite;

endmodule

// File: tb/tb_ucsbece154b_hazard_ctrl.sv
// Self-checking bench for ucsbece154b_hazard_ctrl: a MUL_LAT=3 instance plus a MUL_LAT=1
// instance driven from the same inputs.
module tb_ucsbece154b_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] f3 = '0;
    logic       f7b5 = 1'b0, f7b0 = 1'b0, zeroE = 1'b0;
    logic [4:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, rdE = '0, rdM = '0, rdW = '0;

    logic       stallF, stallD, stallE, flushD, flushE, pcSrcE, pcTgtE, aluSrcE;
    logic       memWriteM, regWriteM, regWriteW;
    logic [2:0] immSrcD;
    logic [3:0] aluCtlE;
    logic [1:0] fwdA, fwdB, resSrcM, resSrcW;

    logic       stallF1, stallD1, stallE1, flushD1, flushE1, pcSrcE1, pcTgtE1, aluSrcE1;
    logic       memWriteM1, regWriteM1, regWriteW1;
    logic [2:0] immSrcD1;
    logic [3:0] aluCtlE1;
    logic [1:0] fwdA1, fwdB1, resSrcM1, resSrcW1;

    int passCount = 0;
    int totalCount = 0;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
        logic [3:0] aluCtl;
        logic       aluSrc;
        logic [2:0] immSrc;
    } expT;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       b5;
    } instT;

    expT  qE[$];
    expT  qM[$];
    expT  qW[$];
    logic qMul[$];

    always #5 clk = ~clk;

    ucsbece154b_hazard_ctrl dut (
        .clk(clk), .reset(reset), .op_i(op), .funct3_i(f3), .funct7b5_i(f7b5), .funct7b0_i(f7b0),
        .ZeroE_i(zeroE), .Rs1D_i(rs1D), .Rs2D_i(rs2D), .Rs1E_i(rs1E), .Rs2E_i(rs2E),
        .RdE_i(rdE), .RdM_i(rdM), .RdW_i(rdW),
        .StallF_o(stallF), .StallD_o(stallD), .StallE_o(stallE), .FlushD_o(flushD), .FlushE_o(flushE),
        .ImmSrcD_o(immSrcD), .PCSrcE_o(pcSrcE), .PCTargetSrcE_o(pcTgtE), .ALUControlE_o(aluCtlE),
        .ALUSrcE_o(aluSrcE), .ForwardAE_o(fwdA), .ForwardBE_o(fwdB), .MemWriteM_o(memWriteM),
        .ResultSrcM_o(resSrcM), .ResultSrcW_o(resSrcW), .RegWriteM_o(regWriteM), .RegWriteW_o(regWriteW)
    );

    ucsbece154b_hazard_ctrl #(.MUL_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .op_i(op), .funct3_i(f3), .funct7b5_i(f7b5), .funct7b0_i(f7b0),
        .ZeroE_i(zeroE), .Rs1D_i(rs1D), .Rs2D_i(rs2D), .Rs1E_i(rs1E), .Rs2E_i(rs2E),
        .RdE_i(rdE), .RdM_i(rdM), .RdW_i(rdW),
        .StallF_o(stallF1), .StallD_o(stallD1), .StallE_o(stallE1), .FlushD_o(flushD1), .FlushE_o(flushE1),
        .ImmSrcD_o(immSrcD1), .PCSrcE_o(pcSrcE1), .PCTargetSrcE_o(pcTgtE1), .ALUControlE_o(aluCtlE1),
        .ALUSrcE_o(aluSrcE1), .ForwardAE_o(fwdA1), .ForwardBE_o(fwdB1), .MemWriteM_o(memWriteM1),
        .ResultSrcM_o(resSrcM1), .ResultSrcW_o(resSrcW1), .RegWriteM_o(regWriteM1), .RegWriteW_o(regWriteW1)
    );

    // Reference decode written from the opcode/funct tables, independent of the RTL structure.
    function automatic expT model(input logic [6:0] o, input logic [2:0] fn3, input logic b5, input logic b0);
        expT e;
        logic [3:0] alu;
        e = '0;
        if (fn3 == 3'b010)      alu = 4'b0101;
        else if (fn3 == 3'b110) alu = 4'b0011;
        else if (fn3 == 3'b111) alu = 4'b0010;
        else                    alu = 4'b0000;
        if (o == 7'b0110011) begin
            e.regWrite = 1'b1;
            e.aluCtl   = b0 ? 4'b1000 : ((fn3 == 3'b000 && b5) ? 4'b0001 : alu);
        end else if (o == 7'b0010011) begin
            e.regWrite = 1'b1; e.aluSrc = 1'b1; e.aluCtl = alu;
        end else if (o == 7'b0000011) begin
            e.regWrite = 1'b1; e.resultSrc = 2'b01; e.aluSrc = 1'b1;
        end else if (o == 7'b0100011) begin
            e.memWrite = 1'b1; e.aluSrc = 1'b1; e.immSrc = 3'b001;
        end else if (o == 7'b0110111) begin
            e.regWrite = 1'b1; e.resultSrc = 2'b11; e.immSrc = 3'b100;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setD(input logic [6:0] o, input logic [2:0] fn3, input logic b5, input logic b0);
        op = o; f3 = fn3; f7b5 = b5; f7b0 = b0;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        setD(7'd0, 3'd0, 1'b0, 1'b0);
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        zeroE = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        op = 7'($urandom); f3 = 3'($urandom); f7b5 = 1'($urandom); f7b0 = 1'($urandom);
        zeroE = 1'($urandom);
        rs1E = 5'd3; rs2E = 5'd4; rdM = 5'd3; rdW = 5'd4; rs1D = 5'd2; rdE = 5'd2;
        tick();
        tick();
        totalCount++;
        if ({regWriteM, resSrcM, memWriteM, regWriteW, resSrcW, aluCtlE, aluSrcE, pcTgtE, pcSrcE} !== 15'd0)
            $display("[TB] FAIL reset_regs: got %b expected 0",
                     {regWriteM, resSrcM, memWriteM, regWriteW, resSrcW, aluCtlE, aluSrcE, pcTgtE, pcSrcE});
        else passCount++;
        totalCount++;
        if ({fwdA, fwdB} !== 4'b0000) $display("[TB] FAIL reset_fwd: got %b expected 0000", {fwdA, fwdB});
        else passCount++;
        totalCount++;
        if ({stallF, stallD, stallE, flushD, flushE} !== 5'b0)
            $display("[TB] FAIL reset_stall: got %b expected 00000", {stallF, stallD, stallE, flushD, flushE});
        else passCount++;
        applyReset();
    endtask

    task automatic test_decode_stream();
        instT prog [0:11];
        expT  e, m, w;
        prog = '{'{7'b0110011, 3'd0, 1'b0}, '{7'b0110011, 3'd0, 1'b1}, '{7'b0110011, 3'd7, 1'b0},
                 '{7'b0110011, 3'd6, 1'b0}, '{7'b0110011, 3'd2, 1'b0}, '{7'b0110011, 3'd1, 1'b0},
                 '{7'b0010011, 3'd0, 1'b1}, '{7'b0000011, 3'd2, 1'b0}, '{7'b0100011, 3'd2, 1'b0},
                 '{7'b0110111, 3'd0, 1'b0}, '{7'b1111111, 3'd0, 1'b0}, '{7'b0000000, 3'd0, 1'b0}};
        applyReset();
        qE.delete(); qM.delete(); qW.delete();
        qM.push_back('0);
        qW.push_back('0);
        for (int i = 0; i < 14; i++) begin
            if (i < 12) setD(prog[i].op, prog[i].f3, prog[i].b5, 1'b0);
            else        setD(7'd0, 3'd0, 1'b0, 1'b0);
            #1;
            e = model(op, f3, f7b5, 1'b0);
            qE.push_back(e);
            totalCount++;
            if (immSrcD !== e.immSrc) $display("[TB] FAIL imm_src[%0d]: got %b expected %b", i, immSrcD, e.immSrc);
            else passCount++;
            tick();
            e = qE.pop_front();
            m = qM.pop_front();
            w = qW.pop_front();
            totalCount++;
            if ({aluCtlE, aluSrcE} !== {e.aluCtl, e.aluSrc})
                $display("[TB] FAIL stage_E[%0d]: got %b expected %b", i, {aluCtlE, aluSrcE}, {e.aluCtl, e.aluSrc});
            else passCount++;
            totalCount++;
            if ({regWriteM, resSrcM, memWriteM} !== {m.regWrite, m.resultSrc, m.memWrite})
                $display("[TB] FAIL stage_M[%0d]: got %b expected %b", i, {regWriteM, resSrcM, memWriteM},
                         {m.regWrite, m.resultSrc, m.memWrite});
            else passCount++;
            totalCount++;
            if ({regWriteW, resSrcW} !== {w.regWrite, w.resultSrc})
                $display("[TB] FAIL stage_W[%0d]: got %b expected %b", i, {regWriteW, resSrcW}, {w.regWrite, w.resultSrc});
            else passCount++;
            qM.push_back(e);
            qW.push_back(m);
        end
    endtask

    task automatic test_load_use();
        applyReset();
        setD(7'b0000011, 3'd2, 1'b0, 1'b0);
        tick();
        setD(7'b0110011, 3'd0, 1'b0, 1'b0);
        rs1D = 5'd5; rs2D = 5'd1; rdE = 5'd5;
        #1;
        totalCount++;
        if ({stallF, stallD, stallE, flushE, flushD} !== 5'b11010)
            $display("[TB] FAIL lwstall_assert: got %b expected 11010", {stallF, stallD, stallE, flushE, flushD});
        else passCount++;
        tick();
        rdE = 5'd0;
        #1;
        totalCount++;
        if ({stallF, stallD, stallE, flushE} !== 4'b0000)
            $display("[TB] FAIL lwstall_release: got %b expected 0000", {stallF, stallD, stallE, flushE});
        else passCount++;
        totalCount++;
        if ({regWriteM, resSrcM} !== 3'b101) $display("[TB] FAIL lw_in_M: got %b expected 101", {regWriteM, resSrcM});
        else passCount++;
        tick();
        setD(7'd0, 3'd0, 1'b0, 1'b0);
        rs1D = '0; rs2D = '0;
        rs1E = 5'd5; rs2E = 5'd1; rdM = 5'd0; rdW = 5'd5;
        #1;
        totalCount++;
        if ({fwdA, fwdB} !== 4'b0100) $display("[TB] FAIL lw_forward: got %b expected 0100", {fwdA, fwdB});
        else passCount++;
    endtask

    task automatic test_forwarding();
        applyReset();
        setD(7'b0110011, 3'd0, 1'b0, 1'b0);
        tick();
        tick();
        setD(7'd0, 3'd0, 1'b0, 1'b0);
        tick();
        rs1E = 5'd3; rs2E = 5'd3; rdM = 5'd3; rdW = 5'd3;
        #1;
        totalCount++;
        if ({fwdA, fwdB} !== 4'b1010) $display("[TB] FAIL fwd_M_wins: got %b expected 1010", {fwdA, fwdB});
        else passCount++;
        rdM = 5'd0; rs1E = 5'd0;
        #1;
        totalCount++;
        if ({fwdA, fwdB} !== 4'b0001) $display("[TB] FAIL fwd_x0: got %b expected 0001", {fwdA, fwdB});
        else passCount++;
        tick();
        rdM = 5'd3; rs1E = 5'd3;
        #1;
        totalCount++;
        if (fwdA !== 2'b01) $display("[TB] FAIL fwd_M_nowrite: got %b expected 01", fwdA);
        else passCount++;
    endtask

    task automatic test_branch();
        applyReset();
        setD(7'b1100011, 3'b001, 1'b0, 1'b0);
        #1;
        totalCount++;
        if (immSrcD !== 3'b010) $display("[TB] FAIL imm_B: got %b expected 010", immSrcD);
        else passCount++;
        tick();
        setD(7'b1100111, 3'd0, 1'b0, 1'b0);
        zeroE = 1'b0;
        #1;
        totalCount++;
        if ({pcSrcE, pcTgtE, flushD, flushE} !== 4'b1011)
            $display("[TB] FAIL bne_taken: got %b expected 1011", {pcSrcE, pcTgtE, flushD, flushE});
        else passCount++;
        zeroE = 1'b1;
        #1;
        totalCount++;
        if ({pcSrcE, pcTgtE, flushD, flushE} !== 4'b0000)
            $display("[TB] FAIL bne_not_taken: got %b expected 0000", {pcSrcE, pcTgtE, flushD, flushE});
        else passCount++;
        tick();
        setD(7'b1101111, 3'd0, 1'b0, 1'b0);
        #1;
        totalCount++;
        if ({pcSrcE, pcTgtE, flushD, flushE, aluSrcE} !== 5'b11111)
            $display("[TB] FAIL jalr: got %b expected 11111", {pcSrcE, pcTgtE, flushD, flushE, aluSrcE});
        else passCount++;
        totalCount++;
        if (immSrcD !== 3'b011) $display("[TB] FAIL imm_J: got %b expected 011", immSrcD);
        else passCount++;
        tick();
        totalCount++;
        if (pcSrcE !== 1'b0) $display("[TB] FAIL flushed_bubble: got %b expected 0", pcSrcE);
        else passCount++;
        tick();
        totalCount++;
        if ({pcSrcE, pcTgtE, regWriteM} !== 3'b100)
            $display("[TB] FAIL jal: got %b expected 100", {pcSrcE, pcTgtE, regWriteM});
        else passCount++;
    endtask

    task automatic test_mul();
        logic expW;
        applyReset();
        qMul.delete();
        setD(7'b0110011, 3'd0, 1'b0, 1'b1);
        tick();
        setD(7'b0110011, 3'd0, 1'b0, 1'b0);
        qMul.push_back(1'b0); qMul.push_back(1'b0); qMul.push_back(1'b0); qMul.push_back(1'b1);
        #1;
        for (int c = 0; c < 4; c++) begin
            expW = qMul.pop_front();
            totalCount++;
            if ({stallF, stallD, stallE} !== ((c < 2) ? 3'b111 : 3'b000))
                $display("[TB] FAIL mul_stall[%0d]: got %b expected %b", c, {stallF, stallD, stallE},
                         (c < 2) ? 3'b111 : 3'b000);
            else passCount++;
            totalCount++;
            if (aluCtlE !== ((c < 3) ? 4'b1000 : 4'b0000))
                $display("[TB] FAIL mul_aluctl[%0d]: got %b expected %b", c, aluCtlE, (c < 3) ? 4'b1000 : 4'b0000);
            else passCount++;
            totalCount++;
            if (regWriteM !== expW) $display("[TB] FAIL mul_M[%0d]: got %b expected %b", c, regWriteM, expW);
            else passCount++;
            if (c == 0) begin
                totalCount++;
                if ({stallF1, stallD1, stallE1, flushE1} !== 4'b0000)
                    $display("[TB] FAIL mul_lat1_stall: got %b expected 0000", {stallF1, stallD1, stallE1, flushE1});
                else passCount++;
            end
            if (c == 1) begin
                totalCount++;
                if ({regWriteM1, aluCtlE1} !== 5'b10000)
                    $display("[TB] FAIL mul_lat1_pipe: got %b expected 10000", {regWriteM1, aluCtlE1});
                else passCount++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_mul();
        applyReset();
        setD(7'b0110011, 3'd0, 1'b0, 1'b1);
        tick();
        setD(7'b0110011, 3'd0, 1'b0, 1'b0);
        tick();
        totalCount++;
        if ({stallF, stallD, stallE} !== 3'b111)
            $display("[TB] FAIL busy_stall: got %b expected 111", {stallF, stallD, stallE});
        else passCount++;
        reset = 1'b0;
        tick();
        totalCount++;
        if ({stallF, stallD, stallE, aluCtlE, regWriteM, regWriteW} !== 9'd0)
            $display("[TB] FAIL reset_mid_mul: got %b expected 0",
                     {stallF, stallD, stallE, aluCtlE, regWriteM, regWriteW});
        else passCount++;
        reset = 1'b1;
        setD(7'd0, 3'd0, 1'b0, 1'b0);
        tick();
        totalCount++;
        if ({stallF, stallD, stallE} !== 3'b000)
            $display("[TB] FAIL post_reset_idle: got %b expected 000", {stallF, stallD, stallE});
        else passCount++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_decode_stream();
        test_load_use();
        test_forwarding();
        test_branch();
        test_mul();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
